// File: rtl/coherent_bus_arbiter.sv
// coherent_bus_arbiter
//   Shares one RAM port between CPUS cache pairs. Data requests take priority over
//   instruction fetches. Each class has its own round-robin pointer. Coherent data
//   misses run a snoop phase. That phase broadcasts the address, invalidates on
//   write intent and, when a peer holds the line dirty, lets that peer flush it.
//   The flush goes to RAM and to the requester in the same beat.
//
//   Ports
//     CLK, nRST            clock (rising edge), asynchronous active-low reset
//     iREN/iaddr           per-CPU instruction fetch request and address
//     dREN/dWEN/daddr      per-CPU data read/write request and address
//     dstore               per-CPU write (or snoop flush) data
//     cctrans/ccwrite      request needs coherence / has write intent
//     iwait/dwait          per-CPU stall, 0 = beat accepted this cycle
//     iload/dload          per-CPU read data
//     ccwait/ccinv         snoop in progress / invalidate, per snooped CPU
//     ccsnoopaddr          per-CPU snoop address, all ones when not snooped
//     ramREN/ramWEN        RAM strobes
//     ramaddr/ramstore     RAM address and write data
//     ramload/ramstate     RAM read data and status (FREE, BUSY, ACCESS, ERROR)
//
//   State | meaning
//   IDLE  | arbitrate: data before instruction, round-robin within each class
//   SNOOP | one cycle of snoop broadcast to every CPU except the owner
//   RESP  | snooped caches answer; a peer write request means a dirty flush
//   FLUSH | supplier writes RAM; the same data is forwarded to the owner
//   DRD   | owner data read from RAM
//   DWR   | owner data write to RAM
//   IRD   | owner instruction fetch from RAM
module coherent_bus_arbiter #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*ADDR_W-1:0]   iaddr,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*ADDR_W-1:0]   daddr,
    input  logic [CPUS*DATA_W-1:0]   dstore,
    input  logic [CPUS-1:0]          cctrans,
    input  logic [CPUS-1:0]          ccwrite,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*DATA_W-1:0]   iload,
    output logic [CPUS*DATA_W-1:0]   dload,
    output logic [CPUS-1:0]          ccwait,
    output logic [CPUS-1:0]          ccinv,
    output logic [CPUS*ADDR_W-1:0]   ccsnoopaddr,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [DATA_W-1:0]        ramstore,
    input  logic [DATA_W-1:0]        ramload,
    input  logic [1:0]               ramstate
);

    localparam int IDX_W = $clog2(CPUS);

    typedef enum logic [2:0] {IDLE, SNOOP, RESP, FLUSH, DRD, DWR, IRD} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    own_q, sup_q, dptr_q, iptr_q;

    logic [CPUS-1:0]     dreq, own_mask, peer_dwen;
    logic [IDX_W-1:0]    dpick, ipick, sup_pick, own_inc;
    logic [ADDR_W-1:0]   own_daddr, own_iaddr, sup_daddr;
    logic [DATA_W-1:0]   own_dstore, sup_dstore;
    logic                ram_access, snoop_active;

    // First requester at or after ptr, wrapping modulo CPUS.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [CPUS-1:0] req,
                                                  input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= CPUS) idx = idx - CPUS;
            if (req[idx]) pick = IDX_W'(idx);
        end
        return pick;
    endfunction

    assign dreq       = dREN | dWEN;
    assign dpick      = rr_pick(dreq, dptr_q);
    assign ipick      = rr_pick(iREN, iptr_q);
    assign own_mask   = CPUS'(1) << own_q;
    assign peer_dwen  = dWEN & ~own_mask;
    assign own_inc    = (int'(own_q) == CPUS - 1) ? '0 : own_q + 1'b1;
    assign own_daddr  = daddr[int'(own_q)*ADDR_W +: ADDR_W];
    assign own_iaddr  = iaddr[int'(own_q)*ADDR_W +: ADDR_W];
    assign own_dstore = dstore[int'(own_q)*DATA_W +: DATA_W];
    assign sup_daddr  = daddr[int'(sup_q)*ADDR_W +: ADDR_W];
    assign sup_dstore = dstore[int'(sup_q)*DATA_W +: DATA_W];
    assign ram_access = (ramstate == 2'd2);
    assign snoop_active = (state_q == SNOOP) || (state_q == RESP) || (state_q == FLUSH);

    // Lowest-numbered peer asking to write back supplies the line.
    always_comb begin
        sup_pick = '0;
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (peer_dwen[j]) sup_pick = IDX_W'(j);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            own_q   <= '0;
            sup_q   <= '0;
            dptr_q  <= '0;
            iptr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|dreq) begin
                        own_q <= dpick;
                        if (cctrans[dpick])   state_q <= SNOOP;
                        else if (dREN[dpick]) state_q <= DRD;
                        else                  state_q <= DWR;
                    end else if (|iREN) begin
                        own_q   <= ipick;
                        state_q <= IRD;
                    end
                end
                SNOOP: state_q <= RESP;
                RESP: begin
                    if (|peer_dwen) begin
                        sup_q   <= sup_pick;
                        state_q <= FLUSH;
                    end else if (dREN[own_q]) state_q <= DRD;
                    else if (dWEN[own_q])     state_q <= DWR;
                    else                      state_q <= IDLE;   // withdrawn: pointer unchanged
                end
                FLUSH: begin
                    if (!dWEN[sup_q]) begin
                        if (dREN[own_q])      state_q <= DRD;
                        else if (dWEN[own_q]) state_q <= DWR;
                        else begin
                            state_q <= IDLE;
                            dptr_q  <= own_inc;
                        end
                    end
                end
                DRD: if (!dREN[own_q]) begin state_q <= IDLE; dptr_q <= own_inc; end
                DWR: if (!dWEN[own_q]) begin state_q <= IDLE; dptr_q <= own_inc; end
                IRD: if (!iREN[own_q]) begin state_q <= IDLE; iptr_q <= own_inc; end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '1;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        if (snoop_active) begin
            for (int j = 0; j < CPUS; j++) begin
                if (!own_mask[j]) begin
                    ccwait[j] = 1'b1;
                    ccinv[j]  = ccwrite[own_q];
                    ccsnoopaddr[j*ADDR_W +: ADDR_W] = own_daddr;
                end
            end
        end

        case (state_q)
            FLUSH: begin
                ramWEN   = 1'b1;
                ramaddr  = sup_daddr;
                ramstore = sup_dstore;
                dload[int'(own_q)*DATA_W +: DATA_W] = sup_dstore;
                if (ram_access) begin
                    dwait[sup_q] = 1'b0;
                    // Cache-to-cache forward rides the same write beat.
                    if (dREN[own_q]) dwait[own_q] = 1'b0;
                end
            end
            DRD: begin
                ramREN  = 1'b1;
                ramaddr = own_daddr;
                dload[int'(own_q)*DATA_W +: DATA_W] = ramload;
                if (ram_access) dwait[own_q] = 1'b0;
            end
            DWR: begin
                ramWEN   = 1'b1;
                ramaddr  = own_daddr;
                ramstore = own_dstore;
                if (ram_access) dwait[own_q] = 1'b0;
            end
            IRD: begin
                ramREN  = 1'b1;
                ramaddr = own_iaddr;
                iload[int'(own_q)*DATA_W +: DATA_W] = ramload;
                if (ram_access) iwait[own_q] = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherent_bus_arbiter.sv
// tb_coherent_bus_arbiter
//   Directed bench for a four-CPU coherent_bus_arbiter. The scenarios run in a fixed
//   order, so the round-robin pointers carry over from one task into the next.
module tb_coherent_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              CLK = 1'b0;
    logic              nRST = 1'b1;
    logic [N-1:0]      iREN = '0, dREN = '0, dWEN = '0, cctrans = '0, ccwrite = '0;
    logic [N*AW-1:0]   iaddr = '0, daddr = '0;
    logic [N*DW-1:0]   dstore = '0;
    logic [N-1:0]      iwait, dwait, ccwait, ccinv;
    logic [N*DW-1:0]   iload, dload;
    logic [N*AW-1:0]   ccsnoopaddr;
    logic              ramREN, ramWEN;
    logic [AW-1:0]     ramaddr;
    logic [DW-1:0]     ramstore;
    logic [DW-1:0]     ramload = '0;
    logic [1:0]        ramstate = 2'd0;

    int n_cmp = 0;
    int n_err = 0;

    coherent_bus_arbiter #(.CPUS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_req();
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    endtask

    task automatic test_reset();
        #1 nRST = 1'b0;
        clear_req();
        #2;
        n_cmp++; if (iwait !== 4'hF) begin n_err++; $display("FAIL reset_iwait: got %b want %b", iwait, 4'hF); end
        n_cmp++; if (dwait !== 4'hF) begin n_err++; $display("FAIL reset_dwait: got %b want %b", dwait, 4'hF); end
        n_cmp++; if ({ccwait, ccinv} !== 8'h00) begin n_err++; $display("FAIL reset_cc: got %b want 0", {ccwait, ccinv}); end
        n_cmp++; if (ccsnoopaddr !== {(N*AW){1'b1}}) begin n_err++; $display("FAIL reset_snoopaddr: got %h want all ones", ccsnoopaddr); end
        n_cmp++; if ({ramREN, ramWEN, ramaddr, ramstore} !== 66'd0) begin n_err++; $display("FAIL reset_ram: got ren=%b wen=%b addr=%h store=%h want 0", ramREN, ramWEN, ramaddr, ramstore); end
        n_cmp++; if ({iload, dload} !== '0) begin n_err++; $display("FAIL reset_loads: got %h %h want 0", iload, dload); end
        // A request seen while reset is held must not start anything.
        dREN = 4'b0001; ramstate = 2'd2;
        tick();
        n_cmp++; if (dwait !== 4'hF || ramREN !== 1'b0) begin n_err++; $display("FAIL reset_hold: got dwait=%b ren=%b want 1111/0", dwait, ramREN); end
        clear_req(); ramstate = 2'd0;
        @(negedge CLK) nRST = 1'b1;
        tick();
    endtask

    // dptr goes 0 -> 1 via a CPU0 read, then CPU0 and CPU2 collide with dptr=1.
    task automatic test_rr_data();
        daddr[0*AW +: AW] = 32'h10; dREN = 4'b0001; ramstate = 2'd2; ramload = 32'h1111_1111;
        #1;
        n_cmp++; if (dwait !== 4'hF) begin n_err++; $display("FAIL idle_no_accept: got %b want 1111", dwait); end
        tick();
        n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'h10) begin n_err++; $display("FAIL drd0_ram: got ren=%b addr=%h want 1/10", ramREN, ramaddr); end
        n_cmp++; if (dwait !== 4'b1110) begin n_err++; $display("FAIL drd0_dwait: got %b want 1110", dwait); end
        n_cmp++; if (dload[0*DW +: DW] !== 32'h1111_1111) begin n_err++; $display("FAIL drd0_dload: got %h want 11111111", dload[0*DW +: DW]); end
        dREN = 4'b0000;
        tick();
        daddr[0*AW +: AW] = 32'h100; daddr[2*AW +: AW] = 32'h200; dREN = 4'b0101; ramload = 32'h2222_2222;
        tick();
        n_cmp++; if (ramaddr !== 32'h200 || dwait !== 4'b1011) begin n_err++; $display("FAIL rr_first_cpu2: got addr=%h dwait=%b want 200/1011", ramaddr, dwait); end
        n_cmp++; if (dload[2*DW +: DW] !== 32'h2222_2222 || dload[0*DW +: DW] !== 32'h0) begin n_err++; $display("FAIL rr_cpu2_dload: got %h want 0000000022222222 in lanes 2/0", dload); end
        dREN = 4'b0001;
        tick();
        n_cmp++; if (dwait !== 4'hF || ramREN !== 1'b0) begin n_err++; $display("FAIL turnaround_idle: got dwait=%b ren=%b want 1111/0", dwait, ramREN); end
        tick();
        n_cmp++; if (ramaddr !== 32'h100 || dwait !== 4'b1110) begin n_err++; $display("FAIL rr_second_cpu0: got addr=%h dwait=%b want 100/1110", ramaddr, dwait); end
        dREN = 4'b0000;
        tick();
    endtask

    // dptr=1. CPU1 BusRdX competes with a plain CPU0 read; CPU1 must win.
    task automatic test_snoop_busrdx();
        dREN = 4'b0011; cctrans = 4'b0010; ccwrite = 4'b0010;
        daddr[1*AW +: AW] = 32'h40; daddr[0*AW +: AW] = 32'h100; ramstate = 2'd2;
        tick();
        n_cmp++; if (ccwait !== 4'b1101) begin n_err++; $display("FAIL snoop_ccwait: got %b want 1101", ccwait); end
        n_cmp++; if (ccinv !== 4'b1101) begin n_err++; $display("FAIL snoop_ccinv: got %b want 1101", ccinv); end
        n_cmp++; if (ccsnoopaddr !== {32'h40, 32'h40, 32'hFFFF_FFFF, 32'h40}) begin n_err++; $display("FAIL snoop_addr: got %h want 00000040_00000040_ffffffff_00000040", ccsnoopaddr); end
        n_cmp++; if (dwait !== 4'hF || ramREN !== 1'b0 || ramWEN !== 1'b0) begin n_err++; $display("FAIL snoop_quiet: got dwait=%b ren=%b wen=%b want 1111/0/0", dwait, ramREN, ramWEN); end
        tick();
        n_cmp++; if (ccwait !== 4'b1101 || ramREN !== 1'b0) begin n_err++; $display("FAIL resp_hold: got ccwait=%b ren=%b want 1101/0", ccwait, ramREN); end
        tick();
        n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'h40 || dwait !== 4'b1101) begin n_err++; $display("FAIL busrdx_drd: got ren=%b addr=%h dwait=%b want 1/40/1101", ramREN, ramaddr, dwait); end
        n_cmp++; if (ccwait !== 4'b0000) begin n_err++; $display("FAIL drd_ccwait: got %b want 0000", ccwait); end
        dREN = 4'b0001; cctrans = '0; ccwrite = '0;
        tick();
        tick();
        n_cmp++; if (ramaddr !== 32'h100 || dwait !== 4'b1110) begin n_err++; $display("FAIL after_snoop_cpu0: got addr=%h dwait=%b want 100/1110", ramaddr, dwait); end
        dREN = 4'b0000;
        tick();
    endtask

    // dptr=1. CPU0 BusRd 0x80, CPU1 holds the line dirty and flushes it.
    task automatic test_flush();
        dREN = 4'b0001; cctrans = 4'b0001; daddr[0*AW +: AW] = 32'h80; ramstate = 2'd1;
        tick();
        n_cmp++; if (ccwait !== 4'b1110 || ccinv !== 4'b0000) begin n_err++; $display("FAIL busrd_snoop: got ccwait=%b ccinv=%b want 1110/0000", ccwait, ccinv); end
        n_cmp++; if (ccsnoopaddr[1*AW +: AW] !== 32'h80 || ccsnoopaddr[0*AW +: AW] !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL busrd_snoopaddr: got %h want 80 in lane1, ones in lane0", ccsnoopaddr); end
        dWEN = 4'b0010; daddr[1*AW +: AW] = 32'h80; dstore[1*DW +: DW] = 32'hDEAD_BEEF;
        tick();
        tick();
        n_cmp++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL flush_ram: got wen=%b ren=%b addr=%h store=%h want 1/0/80/deadbeef", ramWEN, ramREN, ramaddr, ramstore); end
        n_cmp++; if (dload[0*DW +: DW] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL flush_forward: got %h want deadbeef", dload[0*DW +: DW]); end
        n_cmp++; if (dwait !== 4'hF) begin n_err++; $display("FAIL flush_busy_wait: got %b want 1111", dwait); end
        ramstate = 2'd2;
        #1;
        n_cmp++; if (dwait !== 4'b1100) begin n_err++; $display("FAIL flush_access_wait: got %b want 1100", dwait); end
        n_cmp++; if (ccwait !== 4'b1110) begin n_err++; $display("FAIL flush_ccwait: got %b want 1110", ccwait); end
    endtask

    // Still in FLUSH from the previous task; reset lands mid-transaction.
    task automatic test_reset_in_flush();
        nRST = 1'b0;
        #1;
        n_cmp++; if (dwait !== 4'hF || iwait !== 4'hF) begin n_err++; $display("FAIL rst_flush_waits: got d=%b i=%b want 1111/1111", dwait, iwait); end
        n_cmp++; if (ccwait !== 4'b0000 || ccsnoopaddr !== {(N*AW){1'b1}}) begin n_err++; $display("FAIL rst_flush_snoop: got ccwait=%b addr=%h want 0/all ones", ccwait, ccsnoopaddr); end
        n_cmp++; if (ramWEN !== 1'b0 || dload !== '0) begin n_err++; $display("FAIL rst_flush_ram: got wen=%b dload=%h want 0/0", ramWEN, dload); end
        clear_req();
        @(negedge CLK) nRST = 1'b1;
        tick();
        dREN = 4'b0011; daddr[0*AW +: AW] = 32'h600; daddr[1*AW +: AW] = 32'h700; ramstate = 2'd2;
        tick();
        n_cmp++; if (ramaddr !== 32'h600 || dwait !== 4'b1110) begin n_err++; $display("FAIL dptr_cleared: got addr=%h dwait=%b want 600/1110", ramaddr, dwait); end
        dREN = 4'b0000;
        tick();
    endtask

    // dptr=1, iptr=0. Write-back from CPU3 goes first, then fetches 0..3.
    task automatic test_back_to_back();
        logic [3:0] exp_iw;
        iREN = 4'hF;
        for (int k = 0; k < N; k++) iaddr[k*AW +: AW] = 32'h1000 + k;
        dWEN = 4'b1000; daddr[3*AW +: AW] = 32'h300; dstore[3*DW +: DW] = 32'h3333_3333; ramstate = 2'd2;
        tick();
        n_cmp++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h300 || ramstore !== 32'h3333_3333) begin n_err++; $display("FAIL dwr3_ram: got wen=%b ren=%b addr=%h store=%h want 1/0/300/33333333", ramWEN, ramREN, ramaddr, ramstore); end
        n_cmp++; if (dwait !== 4'b0111 || iwait !== 4'hF) begin n_err++; $display("FAIL dwr3_waits: got d=%b i=%b want 0111/1111", dwait, iwait); end
        dWEN = 4'b0000;
        tick();
        for (int k = 0; k < N; k++) begin
            ramload = 32'hA000_0000 + k;
            exp_iw  = ~(4'b0001 << k);
            tick();
            n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'h1000 + k) begin n_err++; $display("FAIL ird%0d_ram: got ren=%b addr=%h want 1/%h", k, ramREN, ramaddr, 32'h1000 + k); end
            n_cmp++; if (iwait !== exp_iw || iload[k*DW +: DW] !== 32'hA000_0000 + k) begin n_err++; $display("FAIL ird%0d_data: got iwait=%b iload=%h want %b/%h", k, iwait, iload[k*DW +: DW], exp_iw, 32'hA000_0000 + k); end
            iREN[k] = 1'b0;
            tick();
            n_cmp++; if (iwait !== 4'hF) begin n_err++; $display("FAIL ird%0d_release: got %b want 1111", k, iwait); end
        end
    endtask

    // dptr=0. RAM sits in BUSY for 20 DRD cycles, ACCESS on the 21st.
    task automatic test_ram_busy();
        dREN = 4'b0100; daddr[2*AW +: AW] = 32'h500; ramstate = 2'd1;
        tick();
        for (int c = 1; c <= 20; c++) begin
            n_cmp++; if (dwait !== 4'hF || iwait !== 4'hF || ramREN !== 1'b1) begin n_err++; $display("FAIL busy_cycle%0d: got d=%b i=%b ren=%b want 1111/1111/1", c, dwait, iwait, ramREN); end
            tick();
        end
        ramstate = 2'd2;
        #1;
        n_cmp++; if (dwait !== 4'b1011) begin n_err++; $display("FAIL busy_access: got %b want 1011", dwait); end
        tick();
        ramstate = 2'd3;
        #1;
        n_cmp++; if (dwait !== 4'hF) begin n_err++; $display("FAIL error_stall: got %b want 1111", dwait); end
        dREN = 4'b0000; ramstate = 2'd0;
        tick();
        n_cmp++; if (ramREN !== 1'b0 || dwait !== 4'hF) begin n_err++; $display("FAIL busy_release: got ren=%b dwait=%b want 0/1111", ramREN, dwait); end
    endtask

    initial begin
        test_reset();
        test_rr_data();
        test_snoop_busrdx();
        test_flush();
        test_reset_in_flush();
        test_back_to_back();
        test_ram_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
